// File: rtl/tpu_pkg.sv
// Shared TPU definitions: weight-path widths and the weight-fetch DMA state type.
package tpu_pkg;

    localparam int unsigned WT_ROW_BITS  = 64;
    localparam int unsigned WT_ADDR_BITS = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wdma_state_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down counter with a reset value, saturating at 0 and MAX_VAL.
// A simultaneous inc and dec leaves the count unchanged.
module credit_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned INIT_VAL = 0,
    parameter int unsigned MAX_VAL  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] LP_INIT = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_inc && !i_dec && (r_count != LP_MAX)) begin
            w_count_nxt = r_count + LP_ONE;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            w_count_nxt = r_count - LP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= LP_INIT;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/weight_fetch_dma.sv
// Weight-fetch DMA: streams num_tiles*TILE_ROWS rows from DRAM into the weight FIFO,
// gated by FIFO credits and a cap on outstanding DRAM reads.
module weight_fetch_dma
    import tpu_pkg::*;
#(
    parameter int unsigned TILE_ROWS       = 3,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_STRIDE     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WT_ADDR_BITS-1:0] base_addr,
    input  logic [7:0]              num_tiles,
    output logic                    mem_rd_en,
    output logic [WT_ADDR_BITS-1:0] mem_addr,
    input  logic                    mem_ready,
    input  logic                    mem_rd_valid,
    input  logic [WT_ROW_BITS-1:0]  mem_rd_data,
    output logic                    wt_fifo_wr,
    output logic [WT_ROW_BITS-1:0]  wt_fifo_data,
    input  logic                    fifo_pop,
    output logic                    busy,
    output logic                    done,
    output logic [9:0]              rows_pushed
);

    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [OUT_W-1:0]        LP_MAX_OUT = OUT_W'(MAX_OUTSTANDING);
    localparam logic [WT_ADDR_BITS-1:0] LP_STRIDE  = WT_ADDR_BITS'(ADDR_STRIDE);

    wdma_state_t              r_state;
    wdma_state_t              w_state_nxt;
    logic [WT_ADDR_BITS-1:0]  r_addr;
    logic [9:0]               r_rows_to_issue;
    logic [9:0]               r_rows_to_recv;
    logic [9:0]               r_rows_pushed;
    logic                     r_wr;
    logic [WT_ROW_BITS-1:0]   r_data;
    logic                     r_done;

    logic [CRED_W-1:0]        w_credits;
    logic [OUT_W-1:0]         w_outstanding;
    logic [9:0]               w_total_rows;
    logic                     w_start_ok;
    logic                     w_accept;
    logic                     w_ret;

    assign w_total_rows = 10'(num_tiles) * 10'(TILE_ROWS);
    assign w_start_ok   = (r_state == IDLE) && start;

    assign mem_rd_en = (r_state == FETCH) && (r_rows_to_issue != '0) && (w_credits != '0)
                       && (w_outstanding < LP_MAX_OUT);
    assign w_accept  = mem_rd_en && mem_ready;

    // Returns outside an active job, or with nothing in flight, are stale and dropped.
    assign w_ret = mem_rd_valid && ((r_state == FETCH) || (r_state == DRAIN))
                   && (w_outstanding != '0);

    credit_counter #(
        .WIDTH    (CRED_W),
        .INIT_VAL (FIFO_DEPTH),
        .MAX_VAL  (FIFO_DEPTH)
    ) u_credits (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (fifo_pop),
        .i_dec   (w_accept),
        .o_count (w_credits)
    );

    credit_counter #(
        .WIDTH    (OUT_W),
        .INIT_VAL (0),
        .MAX_VAL  (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_accept),
        .i_dec   (w_ret),
        .o_count (w_outstanding)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (w_total_rows != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (w_accept && (r_rows_to_issue == 10'd1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_rows_to_recv == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_rows_to_issue <= '0;
            r_rows_to_recv  <= '0;
            r_rows_pushed   <= '0;
            r_wr            <= 1'b0;
            r_data          <= '0;
            r_done          <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == DONE);
            r_wr    <= w_ret;
            if (w_start_ok) begin
                r_addr          <= base_addr;
                r_rows_to_issue <= w_total_rows;
                r_rows_to_recv  <= w_total_rows;
                r_rows_pushed   <= '0;
            end
            if (w_accept) begin
                r_addr          <= r_addr + LP_STRIDE;
                r_rows_to_issue <= r_rows_to_issue - 10'd1;
            end
            if (w_ret) begin
                r_data         <= mem_rd_data;
                r_rows_to_recv <= r_rows_to_recv - 10'd1;
                r_rows_pushed  <= r_rows_pushed + 10'd1;
            end
        end
    end

    assign mem_addr     = r_addr;
    assign wt_fifo_wr   = r_wr;
    assign wt_fifo_data = r_data;
    assign done         = r_done;
    assign rows_pushed  = r_rows_pushed;
    assign busy         = (r_state != IDLE) && (r_state != DONE);

endmodule

// File: tb/tb_weight_fetch_dma.sv
// Directed bench for weight_fetch_dma with a fixed-latency DRAM model and a FIFO consumer.
module tb_weight_fetch_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] base_addr;
    logic [7:0]  num_tiles;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_data;
    logic        wt_fifo_wr;
    logic [63:0] wt_fifo_data;
    logic        fifo_pop;
    logic        busy;
    logic        done;
    logic [9:0]  rows_pushed;

    weight_fetch_dma #(
        .TILE_ROWS       (3),
        .FIFO_DEPTH      (8),
        .MAX_OUTSTANDING (4),
        .ADDR_STRIDE     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_tiles    (num_tiles),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .wt_fifo_wr   (wt_fifo_wr),
        .wt_fifo_data (wt_fifo_data),
        .fifo_pop     (fifo_pop),
        .busy         (busy),
        .done         (done),
        .rows_pushed  (rows_pushed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        int          due;
    } req_t;

    int checks = 0;
    int errors = 0;

    // Environment controls and logs
    int          cyc = 0;
    int          lat = 2;
    int          ready_mode = 0;
    bit          pop_every = 1'b1;
    int          pop_pending = 0;
    req_t        q[$];
    logic [23:0] acc_addr[$];
    logic [63:0] push_data[$];
    int          push_cyc[$];
    int          valid_cyc[$];
    int          done_cnt, done_cyc, en_cnt, stall_cnt, unstable_cnt, outst, max_outst;
    bit          prev_stall;
    logic [23:0] prev_addr;

    function automatic logic [63:0] mk_data(input logic [23:0] a);
        return {16'hD00D, ~a, a};
    endfunction

    // DRAM model + consumer + monitor, evaluated 1 time unit after each falling edge.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mk_data(q[0].addr);
            void'(q.pop_front());
            valid_cyc.push_back(cyc);
            if (outst > 0) outst--;
        end else begin
            mem_rd_valid = 1'b0;
        end
        if (!rst_n) outst = 0;
        if (wt_fifo_wr) begin
            push_cyc.push_back(cyc);
            push_data.push_back(wt_fifo_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        mem_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
        if (prev_stall && (!mem_rd_en || mem_addr !== prev_addr)) unstable_cnt++;
        prev_stall = mem_rd_en && !mem_ready;
        prev_addr  = mem_addr;
        if (prev_stall) stall_cnt++;
        if (mem_rd_en) en_cnt++;
        if (mem_rd_en && mem_ready) begin
            acc_addr.push_back(mem_addr);
            q.push_back('{addr: mem_addr, due: cyc + lat});
            outst++;
            if (outst > max_outst) max_outst = outst;
        end
        if (pop_every) begin
            fifo_pop = 1'b1;
        end else if (pop_pending > 0) begin
            fifo_pop = 1'b1;
            pop_pending--;
        end else begin
            fifo_pop = 1'b0;
        end
    end

    task automatic clear_logs();
        acc_addr.delete();
        push_data.delete();
        push_cyc.delete();
        valid_cyc.delete();
        done_cnt = 0; done_cyc = 0; en_cnt = 0; stall_cnt = 0;
        unstable_cnt = 0; max_outst = 0;
    endtask

    task automatic start_job(input logic [23:0] b, input logic [7:0] n, output int s);
        @(negedge clk);
        base_addr = b;
        num_tiles = n;
        start     = 1'b1;
        #2 s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            #2 k++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: done not seen within %0d cycles", name, budget);
        end
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({mem_rd_en, wt_fifo_wr, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_rd_en, wt_fifo_wr, busy, done});
        end
        checks++;
        if (mem_addr !== 24'h0 || wt_fifo_data !== 64'h0 || rows_pushed !== 10'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h data %h rows %0d want 0", mem_addr, wt_fifo_data,
                     rows_pushed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int s;
        lat = 2; ready_mode = 0; pop_every = 1'b1;
        clear_logs();
        start_job(24'h000100, 8'd2, s);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(100, "basic");
        checks++;
        if (acc_addr.size() != 6 || push_data.size() != 6) begin
            errors++;
            $display("FAIL basic_counts: reads %0d pushes %0d want 6 6", acc_addr.size(),
                     push_data.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc_addr[i] !== 24'h000100 + 24'(8 * i) ||
                push_data[i] !== mk_data(24'h000100 + 24'(8 * i)) ||
                push_cyc[i] != valid_cyc[i] + 1) begin
                errors++;
                $display("FAIL basic_row%0d: addr %h data %h pcyc %0d vcyc %0d want addr %h",
                         i, acc_addr[i], push_data[i], push_cyc[i], valid_cyc[i],
                         24'h000100 + 24'(8 * i));
            end
        end
        checks++;
        if (rows_pushed !== 10'd6 || done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: rows %0d done_cnt %0d busy %b want 6 1 0", rows_pushed,
                     done_cnt, busy);
        end
        checks++;
        if (done_cyc != push_cyc[5] + 2) begin
            errors++;
            $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, push_cyc[5] + 2);
        end
    endtask

    task automatic test_credit_stall();
        int s;
        pop_every = 1'b0;
        clear_logs();
        start_job(24'h000400, 8'd4, s);
        repeat (30) @(negedge clk);
        #2;
        checks++;
        if (acc_addr.size() != 8 || mem_rd_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL credit_block: reads %0d en %b busy %b want 8 0 1", acc_addr.size(),
                     mem_rd_en, busy);
        end
        for (int k = 1; k <= 4; k++) begin
            pop_pending = 1;
            repeat (8) @(negedge clk);
            #2;
            checks++;
            if (acc_addr.size() != 8 + k) begin
                errors++;
                $display("FAIL credit_pop%0d: reads %0d want %0d", k, acc_addr.size(), 8 + k);
            end
        end
        wait_done(100, "credit");
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (push_data[i] !== mk_data(24'h000400 + 24'(8 * i))) begin
                errors++;
                $display("FAIL credit_row%0d: data %h want %h", i, push_data[i],
                         mk_data(24'h000400 + 24'(8 * i)));
            end
        end
        checks++;
        if (push_data.size() != 12 || rows_pushed !== 10'd12 || done_cyc != push_cyc[11] + 2) begin
            errors++;
            $display("FAIL credit_end: pushes %0d rows %0d done_cyc %0d want 12 12 %0d",
                     push_data.size(), rows_pushed, done_cyc, push_cyc[11] + 2);
        end
        pop_every = 1'b1;
    endtask

    task automatic test_stall();
        int s;
        lat = 6; ready_mode = 1;
        clear_logs();
        start_job(24'h000800, 8'd2, s);
        wait_done(200, "stall");
        checks++;
        if (stall_cnt == 0 || unstable_cnt != 0 || max_outst > 4) begin
            errors++;
            $display("FAIL stall_req: stalls %0d unstable %0d max_outst %0d want >0 0 <=4",
                     stall_cnt, unstable_cnt, max_outst);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc_addr[i] !== 24'h000800 + 24'(8 * i) ||
                push_data[i] !== mk_data(24'h000800 + 24'(8 * i)) ||
                push_cyc[i] != valid_cyc[i] + 1) begin
                errors++;
                $display("FAIL stall_row%0d: addr %h data %h want addr %h", i, acc_addr[i],
                         push_data[i], 24'h000800 + 24'(8 * i));
            end
        end
        checks++;
        if (rows_pushed !== 10'd6) begin
            errors++;
            $display("FAIL stall_rows: got %0d want 6", rows_pushed);
        end
        ready_mode = 0;
    endtask

    task automatic test_outstanding();
        int s;
        lat = 6;
        clear_logs();
        start_job(24'h000A00, 8'd3, s);
        wait_done(200, "outst");
        checks++;
        if (max_outst != 4) begin
            errors++;
            $display("FAIL outst_max: got %0d want 4", max_outst);
        end
        checks++;
        if (push_data.size() != 9 || rows_pushed !== 10'd9 ||
            push_data[8] !== mk_data(24'h000A40)) begin
            errors++;
            $display("FAIL outst_end: pushes %0d rows %0d last %h want 9 9 %h", push_data.size(),
                     rows_pushed, push_data[8], mk_data(24'h000A40));
        end
        lat = 2;
    endtask

    task automatic test_zero();
        int s;
        clear_logs();
        start_job(24'h123456, 8'd0, s);
        #2;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy: got %b want 0", busy);
        end
        wait_done(20, "zero");
        checks++;
        if (done_cyc != s + 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_done: cyc %0d cnt %0d want %0d 1", done_cyc, done_cnt, s + 2);
        end
        checks++;
        if (en_cnt != 0 || rows_pushed !== 10'd0) begin
            errors++;
            $display("FAIL zero_idle: en_cycles %0d rows %0d want 0 0", en_cnt, rows_pushed);
        end
    endtask

    task automatic test_wrap();
        int s;
        logic [23:0] exp_a[3];
        exp_a[0] = 24'hFFFFF8; exp_a[1] = 24'h000000; exp_a[2] = 24'h000008;
        clear_logs();
        start_job(24'hFFFFF8, 8'd1, s);
        wait_done(100, "wrap");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_addr[i] !== exp_a[i] || push_data[i] !== mk_data(exp_a[i])) begin
                errors++;
                $display("FAIL wrap_row%0d: addr %h data %h want %h", i, acc_addr[i],
                         push_data[i], exp_a[i]);
            end
        end
        checks++;
        if (acc_addr.size() != 3 || rows_pushed !== 10'd3) begin
            errors++;
            $display("FAIL wrap_end: reads %0d rows %0d want 3 3", acc_addr.size(), rows_pushed);
        end
    endtask

    task automatic test_reset_mid_job();
        int s;
        int k = 0;
        lat = 4;
        clear_logs();
        start_job(24'h000300, 8'd1, s);
        while (acc_addr.size() < 2 && k < 20) begin
            @(negedge clk);
            #2 k++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({mem_rd_en, wt_fifo_wr, busy, done} !== 4'b0000 || mem_addr !== 24'h0 ||
            wt_fifo_data !== 64'h0 || rows_pushed !== 10'h0) begin
            errors++;
            $display("FAIL midrst_outputs: ctl %b addr %h data %h rows %0d want all 0",
                     {mem_rd_en, wt_fifo_wr, busy, done}, mem_addr, wt_fifo_data, rows_pushed);
        end
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        checks++;
        if (push_data.size() != 0 || busy !== 1'b0 || rows_pushed !== 10'h0) begin
            errors++;
            $display("FAIL midrst_stale: pushes %0d busy %b rows %0d want 0 0 0",
                     push_data.size(), busy, rows_pushed);
        end
        lat = 2;
        clear_logs();
        start_job(24'h000200, 8'd1, s);
        wait_done(100, "midrst");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_addr[i] !== 24'h000200 + 24'(8 * i) ||
                push_data[i] !== mk_data(24'h000200 + 24'(8 * i))) begin
                errors++;
                $display("FAIL midrst_row%0d: addr %h data %h want addr %h", i, acc_addr[i],
                         push_data[i], 24'h000200 + 24'(8 * i));
            end
        end
        checks++;
        if (rows_pushed !== 10'd3 || done_cnt != 1) begin
            errors++;
            $display("FAIL midrst_end: rows %0d done_cnt %0d want 3 1", rows_pushed, done_cnt);
        end
    endtask

    initial begin
        start        = 1'b0;
        base_addr    = '0;
        num_tiles    = '0;
        mem_ready    = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        fifo_pop     = 1'b0;
        outst        = 0;
        prev_stall   = 1'b0;
        prev_addr    = '0;
        clear_logs();
        test_reset();
        test_basic();
        test_credit_stall();
        test_stall();
        test_outstanding();
        test_zero();
        test_wrap();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_fetch_dma.md
Name: weight_fetch_dma

Overview:
- Producer side of the weight-FIFO push interface.
- On `start`, issues in-order reads to weight DRAM for `num_tiles` tiles of `TILE_ROWS` 64-bit rows each.
- Pushes each returned row into the dual weight FIFO as a one-cycle `wt_fifo_wr` pulse with `wt_fifo_data`.
- Tracks FIFO credits so no push can overflow the FIFO. Reports `busy`/`done` to the controller.

Parameters:
- TILE_ROWS, 3, rows (64-bit words) per weight tile
- FIFO_DEPTH, 8, entries in the downstream weight FIFO; initial credit count
- MAX_OUTSTANDING, 4, maximum DRAM reads accepted but not yet returned
- ADDR_STRIDE, 8, byte increment of mem_addr per row

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch base_addr/num_tiles and begin
- base_addr  in  24  first row byte address
- num_tiles  in  8  tiles to load; 0 is legal
- mem_rd_en  out  1  read request valid
- mem_addr  out  24  read request address
- mem_ready  in  1  request accepted when mem_rd_en && mem_ready
- mem_rd_valid  in  1  read data valid; in order; cannot be stalled
- mem_rd_data  in  64  read data
- wt_fifo_wr  out  1  FIFO push pulse
- wt_fifo_data  out  64  push data
- fifo_pop  in  1  consumer popped one FIFO entry; returns one credit
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- rows_pushed  out  10  rows pushed in the current/last job

Behaviour:
- Reset values:
  - all outputs 0; state IDLE
  - credits = FIFO_DEPTH; outstanding = 0; internal counters 0
- total_rows = num_tiles * TILE_ROWS, computed in 10 bits (max 255*3 = 765).
- States:
  - IDLE: `start` latches addr = base_addr, rows_to_issue = total_rows, rows_to_recv = total_rows, clears rows_pushed. Goes to FETCH if total_rows ≠ 0, else DONE.
  - FETCH: mem_rd_en = (rows_to_issue ≠ 0) && (credits ≠ 0) && (outstanding < MAX_OUTSTANDING). mem_addr = addr.
    - On acceptance: addr += ADDR_STRIDE (mod 2^24, wraps silently); rows_to_issue−1; credits−1; outstanding+1.
    - mem_rd_en is registered-state driven. mem_addr is stable while mem_rd_en && !mem_ready.
    - When rows_to_issue reaches 0, go to DRAIN.
  - DRAIN: wait until rows_to_recv = 0, then go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, then IDLE.
- Return path (active in FETCH and DRAIN):
  - mem_rd_valid registers into wt_fifo_data with wt_fifo_wr = 1 on the next cycle. Latency is exactly 1.
  - Same update: outstanding−1, rows_to_recv−1, rows_pushed+1.
  - wt_fifo_data holds its last value when wt_fifo_wr = 0.
- Credits:
  - fifo_pop adds 1, saturating at FIFO_DEPTH.
  - Same-cycle acceptance and pop: net credit unchanged.
  - Same-cycle acceptance and return: outstanding unchanged.
  - Credits persist across jobs and are not reloaded on start, because the FIFO may still hold rows.
- Boundaries:
  - start while busy: ignored.
  - mem_rd_valid in IDLE/DONE: ignored, no push.
  - mem_rd_valid with outstanding = 0 in FETCH/DRAIN: ignored.
  - credits = 0: issue stalls until a pop arrives. No push ever occurs without a prior credit.
  - reset mid-job: immediate return to reset values. In-flight DRAM returns after reset are ignored.
- busy = (state ≠ IDLE) && (state ≠ DONE).

Decomposition:
- Shared package `tpu_pkg`:
  - typedef `wdma_state_t` {IDLE, FETCH, DRAIN, DONE}
  - constants WT_ROW_BITS = 64, WT_ADDR_BITS = 24
- One natural sub-module `credit_counter` (up/down saturating counter with init value and simultaneous inc/dec). Instantiated for credits; reusable for outstanding.

Test Plan:
- num_tiles = 2, base = 0x000100, mem_ready = 1, 2-cycle memory latency, consumer pops every cycle:
  - 6 reads at 0x100, 0x108 … 0x128
  - 6 wt_fifo_wr pulses in order, each 1 cycle after mem_rd_valid
  - rows_pushed = 6; done pulses once.
- No fifo_pop, FIFO_DEPTH = 8, num_tiles = 4 (12 rows):
  - exactly 8 reads issued, then mem_rd_en = 0
  - 4 single pops release exactly 4 more reads; done after the 12th push.
- mem_ready toggling 1/0, latency 6:
  - outstanding never exceeds 4
  - mem_addr stable during stalls
  - data order preserved.
- num_tiles = 0 -> no mem_rd_en; done pulses 2 cycles after start; rows_pushed = 0.
- base = 0xFFFFF8, num_tiles = 1 -> addresses 0xFFFFF8, 0x000000, 0x000008.
- Assert rst_n low after 2 of 3 reads issued, then return data while in IDLE:
  - all outputs 0, no wt_fifo_wr
  - a new start with num_tiles = 1 completes normally.
